spectrum_run_detector: RTL and testbench

Downstream consumer of the FFT thresholding stage. On each thresholdingDone pulse it reads the 32-bit occupancy bitmap words from threshMem port B, bin 0 first. It reports every contiguous run of above-threshold bins as a (start bin, length) record over a valid/ready interface, and counts the total number of occupied bins. Host/control logic uses the records for channel occupancy decisions.

---
 rtl/spectrum_run_detector_if.sv | 23 ++
 rtl/spectrum_run_detector.sv | 195 +++++++++++++++++++
 tb/tb_spectrum_run_detector.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_run_detector_if.sv
// Run-record handshake between the spectrum run detector and its consumer.
// The master side drives run_valid plus the (start bin, length) record.
// The slave side drives run_ready; a record moves on run_valid & run_ready.
interface spectrum_run_detector_if;
  logic        run_valid;
  logic        run_ready;
  logic [14:0] run_start_bin;
  logic [15:0] run_length;

  modport master (
    output run_valid,
    output run_start_bin,
    output run_length,
    input  run_ready
  );

  modport slave (
    input  run_valid,
    input  run_start_bin,
    input  run_length,
    output run_ready
  );
endinterface

// File: rtl/spectrum_run_detector.sv
// Purpose: scans the occupancy bitmap after each thresholdingDone pulse and reports contiguous runs of set bins.
// Latency: per word RD_LAT+1 fetch cycles then one bin per cycle; a qualifying run ending on a bin is offered on the next cycle.
// Backpressure: a record is held stable while run_ready is low and bin processing stalls until it is accepted.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   thresholdingDone            start pulse (ignored unless idle)
//   transform_width_log2        log2 of bin count, 3..15, latched at start
//   min_run_len                 shortest run that is reported, latched at start
//   threshAddr / threshData     bitmap word read port (data RD_LAT cycles after address)
//   runIf                       run record valid/ready handshake (master side)
//   occupied_count              total set bins of the last scan
//   scan_busy, scan_done        scan in progress / one-cycle completion pulse
//
// Build option: define RUN_DC_MASK_EN to treat bin 0 (DC) as always empty.
module spectrum_run_detector #(
  parameter int RD_LAT = 1,
  parameter int WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   thresholdingDone,
  input  logic [4:0]             transform_width_log2,
  input  logic [15:0]            min_run_len,
  output logic [15:0]            threshAddr,
  input  logic [WORD_W-1:0]      threshData,
  spectrum_run_detector_if.master runIf,
  output logic [15:0]            occupied_count,
  output logic                   scan_busy,
  output logic                   scan_done
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [1:0] LAT_END = 2'(RD_LAT);

  typedef enum logic [2:0] {IDLE, FETCH, SCAN, EMIT, FINISH} state_t;

  state_t state, stateNext, resumeState, scanResume;

  logic [4:0]        widthLog2;
  logic [15:0]       minRunLen;
  logic [WORD_W-1:0] shiftReg;
  logic [BIT_W-1:0]  bitIdx;
  logic [14:0]       binCnt;
  logic [15:0]       runLen;
  logic [14:0]       runStart;
  logic [1:0]        latCnt;
  logic              runValidQ;
  logic [14:0]       runStartQ;
  logic [15:0]       runLengthQ;

  logic [16:0]       binSpan;
  logic [14:0]       lastBinIdx;
  logic              curBit;
  logic              lastBin;
  logic              lastInWord;
  logic [15:0]       endLen;
  logic [14:0]       endStart;
  logic              runEnds;
  logic              keepRun;
  logic              emitNow;

  assign runIf.run_valid     = runValidQ;
  assign runIf.run_start_bin = runStartQ;
  assign runIf.run_length    = runLengthQ;

  // Per-bin decode for the bit currently at the bottom of the shift register.
  always_comb begin
    binSpan    = 17'd1 << widthLog2;
    lastBinIdx = 15'(binSpan - 17'd1);
    curBit     = shiftReg[0];
`ifdef RUN_DC_MASK_EN
    if (binCnt == 15'd0) curBit = 1'b0;
`else
`endif
    lastBin    = (binCnt == lastBinIdx);
    // Small transforms (<32 bins) end the scan inside word 0.
    lastInWord = lastBin || (bitIdx == BIT_W'(WORD_W - 1));
    endLen     = curBit ? runLen + 16'd1 : runLen;
    endStart   = (runLen == 16'd0) ? binCnt : runStart;
    // A clear bit closes an open run; the final bin closes whatever is open,
    // including a run that begins and ends on it. No wrap to bin 0.
    runEnds    = (runLen != 16'd0 || curBit) && (!curBit || lastBin);
    keepRun    = (endLen >= minRunLen);
    emitNow    = (state == SCAN) && runEnds && keepRun;
    if (lastBin)         scanResume = FINISH;
    else if (lastInWord) scanResume = FETCH;
    else                 scanResume = SCAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    scan_busy = 1'b0;
    scan_done = 1'b0;
    case (state)
      IDLE: begin
        if (thresholdingDone) stateNext = FETCH;
      end
      FETCH: begin
        scan_busy = 1'b1;
        if (latCnt == LAT_END) stateNext = SCAN;
      end
      SCAN: begin
        scan_busy = 1'b1;
        stateNext = emitNow ? EMIT : scanResume;
      end
      EMIT: begin
        scan_busy = 1'b1;
        if (runIf.run_ready) stateNext = resumeState;
      end
      FINISH: begin
        scan_done = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widthLog2      <= '0;
      minRunLen      <= '0;
      shiftReg       <= '0;
      bitIdx         <= '0;
      binCnt         <= '0;
      runLen         <= '0;
      runStart       <= '0;
      latCnt         <= '0;
      threshAddr     <= '0;
      occupied_count <= '0;
      runValidQ      <= 1'b0;
      runStartQ      <= '0;
      runLengthQ     <= '0;
      resumeState    <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (thresholdingDone) begin
            widthLog2      <= transform_width_log2;
            minRunLen      <= min_run_len;
            occupied_count <= '0;
            binCnt         <= '0;
            bitIdx         <= '0;
            runLen         <= '0;
            runStart       <= '0;
            latCnt         <= '0;
            threshAddr     <= '0;
          end
        end
        FETCH: begin
          // threshAddr has been stable since entry, so the word is present
          // RD_LAT cycles into this state.
          if (latCnt == LAT_END) begin
            shiftReg <= threshData;
            bitIdx   <= '0;
            latCnt   <= '0;
          end else begin
            latCnt <= latCnt + 2'd1;
          end
        end
        SCAN: begin
          if (curBit) occupied_count <= occupied_count + 16'd1;
          if (runEnds) begin
            runLen <= '0;
            if (keepRun) begin
              runStartQ   <= endStart;
              runLengthQ  <= endLen;
              runValidQ   <= 1'b1;
              resumeState <= scanResume;
            end
          end else if (curBit) begin
            runLen <= runLen + 16'd1;
            if (runLen == 16'd0) runStart <= binCnt;
          end
          shiftReg <= shiftReg >> 1;
          bitIdx   <= bitIdx + 1'b1;
          binCnt   <= binCnt + 15'd1;
          // Address moves on while any record is pending; the next fetch
          // starts its latency count only after the record is accepted.
          if (lastInWord && !lastBin) threshAddr <= threshAddr + 16'd1;
        end
        EMIT: begin
          if (runIf.run_ready) runValidQ <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_run_detector.sv
// Bench for spectrum_run_detector: bitmap memory with configurable read
// latency, a run-list model computed directly from the bitmap, and one
// negedge compare process checking records, holds and scan completion.
module tb_spectrum_run_detector;
  localparam int LAT = 2;

`ifdef RUN_DC_MASK_EN
  localparam bit DCM = 1'b1;
`else
  localparam bit DCM = 1'b0;
`endif

  typedef struct {int s; int l;} run_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        thresholdingDone;
  logic [4:0]  twl;
  logic [15:0] minLen;
  logic [15:0] threshAddr;
  logic [31:0] threshData;
  logic [15:0] occ;
  logic        busy;
  logic        done;

  logic [31:0] mem  [0:1023];
  logic [31:0] pipe [0:2];

  run_t expQ[$];
  int   expCount = 0;
  int   nwordsCur = 1;
  int   doneCnt = 0;
  int   readyMode = 0;
  bit   cmpEn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  spectrum_run_detector_if runIf();

  spectrum_run_detector #(.RD_LAT(LAT), .WORD_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .thresholdingDone(thresholdingDone),
    .transform_width_log2(twl),
    .min_run_len(minLen),
    .threshAddr(threshAddr),
    .threshData(threshData),
    .runIf(runIf),
    .occupied_count(occ),
    .scan_busy(busy),
    .scan_done(done)
  );

  always @(posedge clk) begin
    pipe[0] <= mem[threshAddr[9:0]];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign threshData = pipe[LAT-1];

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walk the bins in order with a sentinel clear bin past the end.
  task automatic buildModel(int n, int ml);
    int nb;
    int s;
    bit v;
    nb = 1 << n;
    s = -1;
    expQ.delete();
    expCount = 0;
    for (int b = 0; b <= nb; b++) begin
      v = (b < nb) ? mem[b / 32][b % 32] : 1'b0;
      if (DCM && b == 0) v = 1'b0;
      if (v) begin
        expCount++;
        if (s < 0) s = b;
      end else if (s >= 0) begin
        if (b - s >= ml) expQ.push_back('{s, b - s});
        s = -1;
      end
    end
    nwordsCur = (n < 5) ? 1 : (1 << (n - 5));
  endtask

  task automatic pulseStart(int n, int ml);
    @(posedge clk); #2;
    twl = 5'(n);
    minLen = 16'(ml);
    thresholdingDone = 1'b1;
    @(posedge clk); #2;
    thresholdingDone = 1'b0;
  endtask

  task automatic doScan(int n, int ml, int mode, bit extraPulse);
    int startDone;
    int budget;
    buildModel(n, ml);
    readyMode = mode;
    startDone = doneCnt;
    pulseStart(n, ml);
    budget = 0;
    while (doneCnt == startDone && budget < 60000) begin
      @(negedge clk);
      budget++;
      if (extraPulse && budget == 5) begin
        thresholdingDone = 1'b1;
        twl = 5'd9;
      end
      if (extraPulse && budget == 6) thresholdingDone = 1'b0;
    end
    if (doneCnt == startDone) check("scan_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("occ_hold", occ, expCount);
    check("idle_busy", busy, 0);
    check("done_pulses", doneCnt - startDone, 1);
  endtask

  // Consumer: always ready, randomly ready, or 10-cycle stall per record.
  initial begin
    int hold;
    hold = 0;
    runIf.run_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (readyMode)
        0: runIf.run_ready = 1'b1;
        1: runIf.run_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (runIf.run_valid && hold < 10) begin
            runIf.run_ready = 1'b0;
            hold++;
          end else if (runIf.run_valid) begin
            runIf.run_ready = 1'b1;
          end else begin
            runIf.run_ready = 1'b0;
            hold = 0;
          end
        end
      endcase
    end
  end

  initial begin
    bit prevHold;
    int pS;
    int pL;
    run_t e;
    prevHold = 1'b0;
    pS = 0;
    pL = 0;
    forever begin
      @(negedge clk);
      if (cmpEn) begin
        if (prevHold) begin
          check("hold_valid", runIf.run_valid, 1);
          check("hold_start", runIf.run_start_bin, pS);
          check("hold_len", runIf.run_length, pL);
        end
        prevHold = runIf.run_valid && !runIf.run_ready;
        pS = runIf.run_start_bin;
        pL = runIf.run_length;
        if (runIf.run_valid && runIf.run_ready) begin
          if (expQ.size() == 0) begin
            check("extra_record", 1, 0);
          end else begin
            e = expQ.pop_front();
            check("run_start", runIf.run_start_bin, e.s);
            check("run_len", runIf.run_length, e.l);
          end
        end
        if (busy) check("addr_range", (int'(threshAddr) < nwordsCur) ? 1 : 0, 1);
        if (done) begin
          check("done_occ", occ, expCount);
          check("done_left", expQ.size(), 0);
          check("done_busy", busy, 0);
          doneCnt++;
        end
      end else begin
        prevHold = 1'b0;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ml;
    rst_n = 1'b0;
    thresholdingDone = 1'b0;
    twl = 5'd5;
    minLen = 16'd0;
    for (int w = 0; w < 1024; w++) mem[w] = 32'h0;
    #12;
    check("rst_addr", threshAddr, 0);
    check("rst_valid", runIf.run_valid, 0);
    check("rst_start", runIf.run_start_bin, 0);
    check("rst_len", runIf.run_length, 0);
    check("rst_occ", occ, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmpEn = 1'b1;

    mem[0] = 32'h0000_00F0;
    buildModel(5, 0);
    check("pin1_n", expQ.size(), 1);
    check("pin1_s", expQ[0].s, 4);
    check("pin1_l", expQ[0].l, 4);
    check("pin1_occ", expCount, 4);
    doScan(5, 0, 0, 1'b0);

    mem[0] = 32'h8000_0000;
    mem[1] = 32'h0000_0003;
    buildModel(6, 0);
    check("pin2_n", expQ.size(), 1);
    check("pin2_s", expQ[0].s, 31);
    check("pin2_l", expQ[0].l, 3);
    doScan(6, 0, 0, 1'b0);

    mem[0] = 32'h8000_0001;
    mem[1] = 32'h0;
    buildModel(5, 0);
    check("pin3_n", expQ.size(), DCM ? 1 : 2);
    check("pin3_last", expQ[expQ.size() - 1].s, 31);
    doScan(5, 0, 0, 1'b0);

    mem[0] = 32'h0000_0F03;
    buildModel(5, 3);
    check("pin4_n", expQ.size(), 1);
    check("pin4_s", expQ[0].s, 8);
    check("pin4_l", expQ[0].l, 4);
    check("pin4_occ", expCount, DCM ? 5 : 6);
    doScan(5, 3, 0, 1'b0);

    doScan(5, 0, 2, 1'b1);

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(3, 8);
      ml = $urandom_range(0, 4);
      for (int w = 0; w < 8; w++) begin
        case ($urandom_range(0, 2))
          0: mem[w] = $urandom & $urandom;
          1: mem[w] = $urandom | $urandom;
          default: mem[w] = $urandom;
        endcase
      end
      doScan(n, ml, 1, 1'b0);
    end

    for (int w = 0; w < 1024; w++) mem[w] = 32'hFFFF_FFFF;
    buildModel(15, 0);
    check("pin6_n", expQ.size(), 1);
    check("pin6_l", expQ[0].l, DCM ? 32767 : 32768);
    check("pin6_occ", expCount, DCM ? 32767 : 32768);
    doScan(15, 0, 0, 1'b0);

    for (int w = 0; w < 1024; w++) mem[w] = $urandom;
    buildModel(15, 0);
    readyMode = 1;
    pulseStart(15, 0);
    repeat (600) @(negedge clk);
    check("mid_busy", busy, 1);
    cmpEn = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_addr", threshAddr, 0);
    check("arst_valid", runIf.run_valid, 0);
    check("arst_start", runIf.run_start_bin, 0);
    check("arst_len", runIf.run_length, 0);
    check("arst_occ", occ, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmpEn = 1'b1;

    for (int w = 0; w < 1024; w++) mem[w] = 32'h0;
    mem[0] = 32'h0000_00F0;
    doScan(5, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
